// File: rtl/stage_wb.sv
// MIPS writeback stage: MEM/WB pipeline register, load extraction, writeback mux,
// retired-instruction counter and sticky misaligned-load flag.
module stage_wb #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              stall,
   input  logic              nop_mem,
   input  logic [1:0]        wbi_mem,
   input  logic [2:0]        loadType_mem,
   input  logic [DATA_W-1:0] aluResult_mem,
   input  logic [DATA_W-1:0] memData_mem,
   input  logic [DATA_W-1:0] pc_mem,
   input  logic [4:0]        regAddr_mem,
   output logic [DATA_W-1:0] writeData,
   output logic [4:0]        writeAddr,
   output logic              regWrite,
   output logic              fwdValid,
   output logic [CNT_W-1:0]  retired,
   output logic              misalign
);

   localparam logic [2:0] LT_LH  = 3'b001;
   localparam logic [2:0] LT_LHU = 3'b010;
   localparam logic [2:0] LT_LB  = 3'b011;
   localparam logic [2:0] LT_LBU = 3'b100;

   logic              nop_q;
   logic [1:0]        wbi_q;
   logic [2:0]        load_type_q;
   logic [DATA_W-1:0] alu_q;
   logic [DATA_W-1:0] mem_q;
   logic [DATA_W-1:0] pc_q;
   logic [4:0]        reg_addr_q;
   logic [CNT_W-1:0]  retired_q;
   logic              misalign_q;

   logic              in_misaligned;
   logic [DATA_W-1:0] load_value;
   logic [15:0]       half_sel;
   logic [7:0]        byte_sel;

   // Misalignment is judged on the incoming instruction so the flag sets on the capture edge
   always_comb begin
      in_misaligned = 1'b0;
      case (loadType_mem)
         LT_LH, LT_LHU: in_misaligned = aluResult_mem[0];
         LT_LB, LT_LBU: in_misaligned = 1'b0;
         default:       in_misaligned = (aluResult_mem[1:0] != 2'b00);
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         nop_q       <= 1'b1;
         wbi_q       <= 2'b00;
         load_type_q <= 3'b000;
         alu_q       <= '0;
         mem_q       <= '0;
         pc_q        <= '0;
         reg_addr_q  <= 5'd0;
         retired_q   <= '0;
         misalign_q  <= 1'b0;
      end else if (!stall) begin
         nop_q       <= nop_mem;
         wbi_q       <= wbi_mem;
         load_type_q <= loadType_mem;
         alu_q       <= aluResult_mem;
         mem_q       <= memData_mem;
         pc_q        <= pc_mem;
         reg_addr_q  <= regAddr_mem;
         if (!nop_mem)
            retired_q <= retired_q + CNT_W'(1);
         if (!nop_mem && wbi_mem == 2'b11 && in_misaligned)
            misalign_q <= 1'b1;
      end
   end

   // Big-endian extraction: offset 0 addresses the most significant byte
   always_comb begin
      half_sel = alu_q[1] ? mem_q[15:0] : mem_q[31:16];
      case (alu_q[1:0])
         2'd0:    byte_sel = mem_q[31:24];
         2'd1:    byte_sel = mem_q[23:16];
         2'd2:    byte_sel = mem_q[15:8];
         default: byte_sel = mem_q[7:0];
      endcase
      case (load_type_q)
         LT_LH:   load_value = {{(DATA_W-16){half_sel[15]}}, half_sel};
         LT_LHU:  load_value = {{(DATA_W-16){1'b0}}, half_sel};
         LT_LB:   load_value = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         LT_LBU:  load_value = {{(DATA_W-8){1'b0}}, byte_sel};
         default: load_value = mem_q;
      endcase
   end

   always_comb begin
      case (wbi_q)
         2'b01:   writeData = alu_q;
         2'b10:   writeData = pc_q + DATA_W'(4);
         2'b11:   writeData = load_value;
         default: writeData = '0;
      endcase
   end

   // A stalled write is deferred, not lost: the latch holds it until stall drops
   assign regWrite  = !nop_q && (wbi_q != 2'b00) && (reg_addr_q != 5'd0) && !stall;
   assign fwdValid  = regWrite;
   assign writeAddr = reg_addr_q;
   assign retired   = retired_q;
   assign misalign  = misalign_q;

endmodule

// File: tb/tb_stage_wb.sv
// Directed scoreboard bench for stage_wb: expectations are queued when an
// instruction is driven and compared one cycle later when it reaches writeback.
module tb_stage_wb;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        nop_mem = 1'b1;
   logic [1:0]  wbi_mem = 2'b00;
   logic [2:0]  loadType_mem = 3'b000;
   logic [31:0] aluResult_mem = '0;
   logic [31:0] memData_mem = '0;
   logic [31:0] pc_mem = '0;
   logic [4:0]  regAddr_mem = '0;
   logic [31:0] writeData;
   logic [4:0]  writeAddr;
   logic        regWrite;
   logic        fwdValid;
   logic [31:0] retired;
   logic        misalign;

   stage_wb #(.DATA_W(32), .CNT_W(32)) dut (
      .clock(clock), .reset(reset), .stall(stall), .nop_mem(nop_mem),
      .wbi_mem(wbi_mem), .loadType_mem(loadType_mem), .aluResult_mem(aluResult_mem),
      .memData_mem(memData_mem), .pc_mem(pc_mem), .regAddr_mem(regAddr_mem),
      .writeData(writeData), .writeAddr(writeAddr), .regWrite(regWrite),
      .fwdValid(fwdValid), .retired(retired), .misalign(misalign)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_retired = 0;
   logic        exp_mis = 1'b0;

   localparam logic [31:0] MD = 32'h80FF7F01;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one instruction into MEM and queue what writeback must show next cycle
   task automatic drive(input logic nop, input logic [1:0] wbi, input logic [2:0] lt,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc,
                        input logic [4:0] ra, input logic ewe, input logic [4:0] eaddr,
                        input logic [31:0] edata);
      exp_t e;
      nop_mem = nop; wbi_mem = wbi; loadType_mem = lt; aluResult_mem = alu;
      memData_mem = mem; pc_mem = pc; regAddr_mem = ra;
      e.we = ewe; e.addr = eaddr; e.data = edata;
      sb.push_back(e);
      if (!stall && !nop) exp_retired = exp_retired + 1;
   endtask

   task automatic cycle(input string tag);
      exp_t e;
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check({tag, " regWrite"}, {31'd0, regWrite}, {31'd0, e.we});
         check({tag, " fwdValid"}, {31'd0, fwdValid}, {31'd0, e.we});
         check({tag, " writeAddr"}, {27'd0, writeAddr}, {27'd0, e.addr});
         check({tag, " writeData"}, writeData, e.data);
      end
      check({tag, " retired"}, retired, exp_retired);
      check({tag, " misalign"}, {31'd0, misalign}, {31'd0, exp_mis});
   endtask

   task automatic check_idle(input string tag);
      check({tag, " regWrite"}, {31'd0, regWrite}, 32'd0);
      check({tag, " fwdValid"}, {31'd0, fwdValid}, 32'd0);
      check({tag, " writeAddr"}, {27'd0, writeAddr}, 32'd0);
      check({tag, " writeData"}, writeData, 32'd0);
      check({tag, " retired"}, retired, 32'd0);
      check({tag, " misalign"}, {31'd0, misalign}, 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clock);
      #1;
      check_idle("reset");
      reset = 1'b1;

      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 2'b00, 3'b000, 0, 0, 0, 5'd0, 1'b0, 5'd0, 32'd0);
         cycle("idle");
      end

      drive(1'b0, 2'b01, 3'b000, 32'h12345678, 0, 0, 5'd5, 1'b1, 5'd5, 32'h12345678);
      cycle("alu_r5");

      drive(1'b0, 2'b11, 3'b011, 32'h1000, MD, 0, 5'd1, 1'b1, 5'd1, 32'hFFFFFF80);
      cycle("lb_o0");
      drive(1'b0, 2'b11, 3'b100, 32'h1000, MD, 0, 5'd2, 1'b1, 5'd2, 32'h00000080);
      cycle("lbu_o0");
      drive(1'b0, 2'b11, 3'b011, 32'h1003, MD, 0, 5'd3, 1'b1, 5'd3, 32'h00000001);
      cycle("lb_o3");
      drive(1'b0, 2'b11, 3'b100, 32'h1001, MD, 0, 5'd4, 1'b1, 5'd4, 32'h000000FF);
      cycle("lbu_o1");
      drive(1'b0, 2'b11, 3'b001, 32'h1002, MD, 0, 5'd6, 1'b1, 5'd6, 32'h00007F01);
      cycle("lh_o2");
      drive(1'b0, 2'b11, 3'b010, 32'h1000, MD, 0, 5'd7, 1'b1, 5'd7, 32'h000080FF);
      cycle("lhu_o0");
      drive(1'b0, 2'b11, 3'b001, 32'h1000, MD, 0, 5'd8, 1'b1, 5'd8, 32'hFFFF80FF);
      cycle("lh_o0");

      exp_mis = 1'b1;
      drive(1'b0, 2'b11, 3'b000, 32'h1002, MD, 0, 5'd9, 1'b1, 5'd9, MD);
      cycle("lw_misaligned");
      drive(1'b0, 2'b11, 3'b010, 32'h1000, MD, 0, 5'd10, 1'b1, 5'd10, 32'h000080FF);
      cycle("lhu_after_mis");
      drive(1'b0, 2'b11, 3'b000, 32'h1004, MD, 0, 5'd11, 1'b1, 5'd11, MD);
      cycle("lw_aligned");

      drive(1'b0, 2'b01, 3'b000, 32'hDEADBEEF, 0, 0, 5'd0, 1'b0, 5'd0, 32'hDEADBEEF);
      cycle("r0_suppress");
      drive(1'b1, 2'b11, 3'b000, 32'h2000, MD, 0, 5'd7, 1'b0, 5'd7, MD);
      cycle("nop_bubble");
      drive(1'b0, 2'b10, 3'b000, 0, 0, 32'hFFFFFFFC, 5'd31, 1'b1, 5'd31, 32'h00000000);
      cycle("link_wrap");
      drive(1'b0, 2'b10, 3'b000, 0, 0, 32'h00400100, 5'd31, 1'b1, 5'd31, 32'h00400104);
      cycle("link");
      drive(1'b0, 2'b00, 3'b000, 32'h55, 0, 0, 5'd12, 1'b0, 5'd12, 32'd0);
      cycle("wbi_none");

      // Stall: r9 is latched, then held for three stalled edges
      drive(1'b0, 2'b01, 3'b000, 32'hCAFEBABE, 0, 0, 5'd9, 1'b1, 5'd9, 32'hCAFEBABE);
      cycle("stall_latch");
      stall = 1'b1;
      #1;
      check("stall_now regWrite", {31'd0, regWrite}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 2'b01, 3'b000, 32'h11111111, 0, 0, 5'd3, 1'b0, 5'd9, 32'hCAFEBABE);
         cycle("stalled");
      end
      stall = 1'b0;
      #1;
      check("stall_release regWrite", {31'd0, regWrite}, 32'd1);
      check("stall_release writeAddr", {27'd0, writeAddr}, 32'd9);
      check("stall_release writeData", writeData, 32'hCAFEBABE);

      // Second stall interrupted by reset: held instruction must vanish
      drive(1'b0, 2'b01, 3'b000, 32'hA5A5A5A5, 0, 0, 5'd10, 1'b1, 5'd10, 32'hA5A5A5A5);
      cycle("stall2_latch");
      stall = 1'b1;
      @(posedge clock);
      #2;
      reset = 1'b0;
      exp_retired = 0;
      exp_mis = 1'b0;
      #1;
      check_idle("reset_in_stall");
      @(posedge clock);
      #1;
      reset = 1'b1;
      stall = 1'b0;
      #1;
      check_idle("after_reset");
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 2'b00, 3'b000, 0, 0, 0, 5'd0, 1'b0, 5'd0, 32'd0);
         cycle("post_reset");
      end
      check("scoreboard_drained", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
